// File: rtl/sa_fifo_20x16_pkg.sv
// Shared sizing and pointer helper for the 20x16 valid/ready FIFO and its RAM.
package sa_fifo_20x16_pkg;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned AW    = 5;

  // Advance a RAM pointer, wrapping from the last entry back to 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

endpackage

// File: rtl/sa_fifo_20x16_if.sv
// Producer/consumer stream bundle of the 20x16 FIFO.
//   wr_pvld/wr_prdy/wr_pd : producer handshake and payload
//   rd_pvld/rd_prdy/rd_pd : consumer handshake and payload
//   fifo_count            : entries accepted and not yet popped
// master = the environment (producer + consumer), slave = the FIFO.
interface sa_fifo_20x16_if;
  import sa_fifo_20x16_pkg::*;

  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic [AW-1:0]    fifo_count;

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd, fifo_count
  );

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd, fifo_count
  );

endinterface

// File: rtl/sa_ram_rwsthp_20x16.sv
// 20x16 two-port RAM model with a two-stage read: the address is captured on
// re, the data on ore. Array, address and data registers are not reset.
//   clk                : clock
//   wa/we/di           : write port
//   ra/re              : read address capture
//   ore                : read data capture
//   dout               : read data (or dbyp when byp_sel)
//   pwrbus_ram_pd      : power control, no functional effect in this model
module sa_ram_rwsthp_20x16
  import sa_fifo_20x16_pkg::*;
(
  input  logic             clk,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  input  logic             byp_sel,
  input  logic [WIDTH-1:0] dbyp,
  input  logic [31:0]      pwrbus_ram_pd
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ra_d;
  logic [WIDTH-1:0] r_dout;
  logic             w_unused_pwr;

  // Write port, read-address stage and read-data stage.
  always_ff @(posedge clk) begin
    if (we)  r_mem[wa] <= di;
    if (re)  r_ra_d    <= ra;
    if (ore) r_dout    <= r_mem[r_ra_d];
  end

  assign dout         = byp_sel ? dbyp : r_dout;
  assign w_unused_pwr = ^pwrbus_ram_pd;

endmodule

// File: rtl/sa_fifo_20x16.sv
// Valid/ready FIFO controller around the 20x16 two-port RAM. Absorbs the
// RAM's two-stage read pipeline (s1 = address held, s2 = data held) so the
// consumer sees a stall-tolerant, one-word-per-cycle stream.
//   nvdla_core_clk  : clock
//   nvdla_core_rstn : async active-low reset
//   pwrbus_ram_pd   : forwarded to the RAM
//   fifo_if         : producer/consumer stream (slave side)
module sa_fifo_20x16
  import sa_fifo_20x16_pkg::*;
(
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic [31:0]           pwrbus_ram_pd,
  sa_fifo_20x16_if.slave        fifo_if
);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_ram_cnt;
  logic [AW-1:0]    r_fifo_count;
  logic             r_s1_vld;
  logic             r_s2_vld;

  logic             w_wr_prdy;
  logic             w_push;
  logic             w_pop;
  logic             w_adv2;
  logic             w_ore;
  logic             w_re;
  logic [WIDTH-1:0] w_dout;

  // Full decode uses the registered count only; a same-cycle pop never
  // opens the write side.
  assign w_wr_prdy = (r_fifo_count != AW'(DEPTH));
  assign w_push    = fifo_if.wr_pvld & w_wr_prdy;
  assign w_pop     = r_s2_vld & fifo_if.rd_prdy;
  assign w_adv2    = ~r_s2_vld | fifo_if.rd_prdy;
  assign w_ore     = r_s1_vld & w_adv2;
  // Issue only when s1 is free or moving on; a stalled s1 keeps ra_d stable.
  assign w_re      = (r_ram_cnt != '0) & (~r_s1_vld | w_ore);

  // Pointers, counters and read-pipeline valids.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_ram_cnt    <= '0;
      r_fifo_count <= '0;
      r_s1_vld     <= 1'b0;
      r_s2_vld     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_re)   r_rd_ptr <= ptr_inc(r_rd_ptr);

      case ({w_push, w_re})
        2'b10:   r_ram_cnt <= r_ram_cnt + AW'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - AW'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase

      case ({w_push, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + AW'(1);
        2'b01:   r_fifo_count <= r_fifo_count - AW'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase

      r_s1_vld <= w_re  | (r_s1_vld & ~w_ore);
      r_s2_vld <= w_ore | (r_s2_vld & ~fifo_if.rd_prdy);
    end
  end

  sa_ram_rwsthp_20x16 u_ram (
    .clk           (nvdla_core_clk),
    .ra            (r_rd_ptr),
    .re            (w_re),
    .ore           (w_ore),
    .dout          (w_dout),
    .wa            (r_wr_ptr),
    .we            (w_push),
    .di            (fifo_if.wr_pd),
    .byp_sel       (1'b0),
    .dbyp          ('0),
    .pwrbus_ram_pd (pwrbus_ram_pd)
  );

  assign fifo_if.wr_prdy    = w_wr_prdy;
  assign fifo_if.rd_pvld    = r_s2_vld;
  assign fifo_if.rd_pd      = w_dout;
  assign fifo_if.fifo_count = r_fifo_count;

endmodule

// File: doc/sa_fifo_20x16.md
Name: sa_fifo_20x16

Overview:
- Valid/ready FIFO controller that drives the 20x16 two-port RAM model from the write side and the read side.
- Generates wa/we/di, ra/re and ore, and absorbs the RAM's 2-stage read pipeline: ra_d is registered on re, and dout_r is registered on ore.
- Presents a stall-tolerant, full-throughput stream to the consumer.
- Sits between a producer datapath and a consumer in the small-config convolution/accumulation pipes.

Parameters:
- DEPTH, 20, entry count; fixed by the RAM, not overridable.
- WIDTH, 16, payload bits; fixed by the RAM.
- AW, 5, pointer width.

Ports:
- nvdla_core_clk  input  1  sole clock.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- wr_pvld  input  1  producer data valid.
- wr_prdy  output  1  FIFO can accept data.
- wr_pd  input  16  producer payload.
- rd_pvld  output  1  output payload valid.
- rd_prdy  input  1  consumer ready.
- rd_pd  output  16  output payload (RAM dout).
- fifo_count  output  5  entries accepted and not yet popped, 0..20.
- pwrbus_ram_pd  input  32  passed straight to the RAM.

Behaviour:
- Reset and clocking: single clock, asynchronous active-low reset on nvdla_core_rstn.
  - Reset clears wr_ptr, rd_ptr, ram_cnt, fifo_count, s1_vld and s2_vld.
  - After reset: rd_pvld=0, fifo_count=0, wr_prdy=1.
  - RAM array and dout_r are not reset. rd_pd is don't-care while rd_pvld=0.
- Write side:
  - push = wr_pvld & wr_prdy.
  - wr_prdy = (fifo_count != 20), decoded from registers only.
  - On push: we=1, wa=wr_ptr, di=wr_pd, and wr_ptr advances, wrapping 19 to 0.
- Read pipeline stages:
  - s1_vld: ra_d holds an issued address.
  - s2_vld: dout_r holds data. rd_pvld = s2_vld and rd_pd = dout.
- Read-side control:
  - pop = s2_vld & rd_prdy.
  - adv2 = !s2_vld | rd_prdy.
  - ore = s1_vld & adv2.
  - re = (ram_cnt != 0) & (!s1_vld | ore). ra = rd_ptr, and rd_ptr wraps 19 to 0 on re.
- Stage valid updates:
  - s1_vld next = re | (s1_vld & !ore).
  - s2_vld next = ore | (s2_vld & !rd_prdy).
- Stall behaviour:
  - While stalled, re=0 holds ra_d, so M[ra_d] stays stable.
  - That slot cannot be overwritten because it is still counted in fifo_count.
- Counters:
  - ram_cnt (written, not yet issued): +push, −re.
  - fifo_count: +push, −pop.
  - Simultaneous push and pop leaves fifo_count unchanged. Simultaneous push and re leaves ram_cnt unchanged.
- Latency and throughput:
  - A push in cycle 0 gives re in cycle 1, ore in cycle 2 and rd_pvld in cycle 3.
  - Sustains 1 word/cycle with rd_prdy held high.
- Bypass: byp_sel=0 and dbyp=0 always. Same-address read-during-write cannot occur, because issue only reads already-written slots.
- Full: with fifo_count=20, a push is refused. A pop in the same cycle does not enable the push; wr_prdy rises the next cycle.
- Empty: with ram_cnt=0, no re is issued. s1 and s2 still drain normally.
- Reset mid-operation: all in-flight and stored words are discarded. rd_pvld drops asynchronously, and the output is empty once reset is released.
- Ordering: strict FIFO order; no data loss or duplication under any pattern of rd_prdy.

Decomposition:
- Shared package: DEPTH=20, WIDTH=16, AW=5, and a pointer-increment-with-wrap function.
- One sub-module, sa_ram_rwsthp_20x16, instantiated as u_ram.
- All control (pointers, ram_cnt, fifo_count, s1/s2 valids) lives in the top level.
- No other hierarchy.

Test Plan:
- Reset, then a single push of 0x1234 in cycle 0 → rd_pvld high in cycle 3 with rd_pd=0x1234, fifo_count=1 until the pop, then 0.
- 20 pushes of values 0..19 with rd_prdy=0 → wr_prdy=0 after the 20th push, fifo_count=20, a 21st push is refused. Then rd_prdy=1 → outputs 0..19 in order; wr_prdy returns 1 the cycle after the first pop.
- Continuous push/pop streaming 40 words (pointer wrap twice) with rd_prdy=1 → one word per cycle after 3-cycle fill, in order, fifo_count steady at 3.
- Random rd_prdy with roughly 50% duty cycle plus random wr_pvld for 1000 words → scoreboard matches exactly. No rd_pd change while rd_pvld=1 and rd_prdy=0.
- At fifo_count=20, simultaneous push and pop → push not accepted, fifo_count=19 the next cycle.
- Assert nvdla_core_rstn mid-stream with 7 words stored and the pipeline full → rd_pvld=0 immediately, fifo_count=0, wr_prdy=1. The next pushed word 0xBEEF is the first word out.
